load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Sits between the CPU execute stage and the word-only data memory. Accepts byte/half/word
//  loads and stores at byte addresses and converts them into 32-bit word accesses.
//  Sub-word stores are done as read-modify-write. Loads return a sign/zero-extended result.
//  Misaligned and out-of-range requests are reported as errors and never touch memory.
// PARAMETERS
//  NUMWORDS   4096  words in the attached memory; memory address width AW = $clog2(NUMWORDS)+1
//  DATAWIDTH  32    word width; only 32 is supported
// PORTS
//  clk_i          in   1   clock
//  rst_i          in   1   reset, asynchronous, active-high
//  req_valid_i    in   1   CPU request valid
//  req_ready_o    out  1   unit can accept a request (high only in IDLE)
//  req_we_i       in   1   1 = store, 0 = load
//  req_size_i     in   2   00 byte, 01 half, 10 word, 11 illegal (error)
//  req_unsigned_i in   1   zero-extend on load (ignored for word and for stores)
//  req_addr_i     in   32  byte address
//  req_wdata_i    in   32  store data; byte/half taken from the low bits
//  resp_valid_o   out  1   one-cycle pulse that completes the request
//  resp_rdata_o   out  32  load result; 0 for stores and errors
//  resp_err_o     out  1   misaligned, illegal size or out-of-range (valid with resp_valid_o)
//  mem_re_o       out  1   memory read enable
//  mem_raddr_o    out  AW  memory word read address
//  mem_rdata_i    in   32  memory read data (combinational, same cycle)
//  mem_we_o       out  1   memory write enable (written at the clk_i edge)
//  mem_waddr_o    out  AW  memory word write address
//  mem_wdata_o    out  32  memory write data
// BEHAVIOUR
//  - Reset: state=IDLE; req_ready_o=1; all other outputs 0; request registers cleared.
//  - Accept: in IDLE, valid&ready registers we/size/unsigned/addr/wdata. Word index =
//    addr[AW+1:2]. Error if any of: size==11; half with addr[0]!=0; word with addr[1:0]!=0;
//    (addr>>2)>=NUMWORDS.
//  - FSM: IDLE -> {ERR | LOAD | ST_WORD | RMW_RD}. LOAD, ST_WORD -> RESP.
//    RMW_RD -> RMW_WR -> RESP. ERR and RESP -> IDLE.
//  - LOAD: mem_re_o=1, raddr=index. Capture the selected lane of mem_rdata_i
//    (little-endian: byte n = bits 8n+7:8n; half at addr[1]). Sign- or zero-extend into the
//    response register.
//  - ST_WORD: mem_we_o=1, waddr=index, wdata=req_wdata.
//  - RMW_RD: mem_re_o=1. Merge the new byte/half into the read word; store it in the merge
//    register.
//  - RMW_WR: mem_we_o=1, wdata=merge register.
//  - mem_re_o and mem_we_o are never high in the same cycle, so the memory's read-during-write
//    forwarding is never used.
//  - RESP / ERR: resp_valid_o=1 for exactly one cycle. ERR sets resp_err_o=1 and
//    resp_rdata_o=0, and issues no memory access.
//  - Latency from the accept edge to the resp_valid_o cycle: error 1, load 2, word store 2,
//    sub-word store 3.
//  - No response backpressure; the CPU must take the resp_valid_o pulse. req_ready_o=0 from
//    accept until the cycle after the response.
//  - Memory address/data outputs are 0 when the matching enable is low.
//  - Reset mid-operation: immediate return to IDLE. An RMW interrupted before the RMW_WR edge
//    leaves memory unmodified.
// STRUCTURE
//  - lsu_pkg: typedef enum lsu_state_e {IDLE, LOAD, ST_WORD, RMW_RD, RMW_WR, RESP, ERR};
//    typedef enum lsu_size_e {SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10}.
//  - lsu_byte_lane: one combinational sub-module. Performs lane extract + sign/zero extend
//    and lane merge for stores, from (size, addr[1:0], unsigned, word, wdata).
// TESTING
//  1 Word store 0x100=0xDEADBEEF, then word load 0x100 -> resp_rdata_o=0xDEADBEEF,
//    2 cycles each, err=0.
//  2 Byte store 0x42 to 0x101 over 0xDEADBEEF -> mem word 0xDEAD42EF. mem_we_o only in
//    RMW_WR; response 3 cycles after accept.
//  3 Load byte 0x103 of 0x80FF7F01: signed -> 0xFFFFFF80, unsigned -> 0x00000080.
//    Load half 0x102 signed -> 0xFFFF80FF.
//  4 Half at 0x0001, word at 0x0002, size 11, addr 4*NUMWORDS -> resp_err_o=1 one cycle after
//    accept; mem_re_o=mem_we_o=0 throughout.
//  5 rst_i pulse while in RMW_RD -> all outputs 0 and req_ready_o=1 immediately; target word
//    unchanged; next request completes normally.
//  6 Back-to-back req_valid_i held high -> each request accepted only in IDLE. Assertion:
//    never (mem_re_o & mem_we_o).

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsu_pkg : shared types and request checks for the load/store unit         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package lsu_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      ST_WORD = 3'd2,
      RMW_RD  = 3'd3,
      RMW_WR  = 3'd4,
      RESP    = 3'd5,
      ERR     = 3'd6
   } lsu_state_e;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10
   } lsu_size_e;

   // Size 2'b11 has no enum member and is always rejected.
   function automatic logic req_error(input logic [1:0] size,
                                      input logic [1:0] addr_lo,
                                      input logic       out_of_range);
      logic bad;
      bad = out_of_range;
      if (size == 2'b11)                     bad = 1'b1;
      if (size == SZ_H && addr_lo[0])        bad = 1'b1;
      if (size == SZ_W && addr_lo != 2'b00)  bad = 1'b1;
      return bad;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_byte_lane.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsu_byte_lane : little-endian lane extract/extend and sub-word store merge |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module lsu_byte_lane
   import lsu_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic        is_unsigned,
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      case (addr_lo)
         2'd0:    w_byte = word[7:0];
         2'd1:    w_byte = word[15:8];
         2'd2:    w_byte = word[23:16];
         default: w_byte = word[31:24];
      endcase
      w_half = addr_lo[1] ? word[31:16] : word[15:0];
   end

   always_comb begin
      load_data = word;
      merged    = wdata;
      case (size)
         SZ_B: begin
            load_data = {{24{~is_unsigned & w_byte[7]}}, w_byte};
            merged    = word;
            case (addr_lo)
               2'd0:    merged[7:0]   = wdata[7:0];
               2'd1:    merged[15:8]  = wdata[7:0];
               2'd2:    merged[23:16] = wdata[7:0];
               default: merged[31:24] = wdata[7:0];
            endcase
         end
         SZ_H: begin
            load_data = {{16{~is_unsigned & w_half[15]}}, w_half};
            merged    = word;
            if (addr_lo[1]) merged[31:16] = wdata[15:0];
            else            merged[15:0]  = wdata[15:0];
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | load_store_unit : byte/half/word CPU accesses onto a word-only memory      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int NUMWORDS  = 4096,
   parameter int DATAWIDTH = 32,
   localparam int AW       = $clog2(NUMWORDS) + 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic                 req_we_i,
   input  logic [1:0]           req_size_i,
   input  logic                 req_unsigned_i,
   input  logic [31:0]          req_addr_i,
   input  logic [DATAWIDTH-1:0] req_wdata_i,
   output logic                 resp_valid_o,
   output logic [DATAWIDTH-1:0] resp_rdata_o,
   output logic                 resp_err_o,
   output logic                 mem_re_o,
   output logic [AW-1:0]        mem_raddr_o,
   input  logic [DATAWIDTH-1:0] mem_rdata_i,
   output logic                 mem_we_o,
   output logic [AW-1:0]        mem_waddr_o,
   output logic [DATAWIDTH-1:0] mem_wdata_o
);

   localparam logic [31:0] c_num_words = NUMWORDS;

   lsu_state_e           r_state, w_next;
   logic                 r_we;
   logic [1:0]           r_size;
   logic                 r_unsigned;
   logic [AW+1:0]        r_addr;
   logic [DATAWIDTH-1:0] r_wdata;
   logic [DATAWIDTH-1:0] r_rdata;
   logic [DATAWIDTH-1:0] r_merge;

   logic                 w_accept;
   logic                 w_err;
   logic [AW-1:0]        w_index;
   logic [DATAWIDTH-1:0] w_load_data;
   logic [DATAWIDTH-1:0] w_merged;

   assign w_accept = req_valid_i && (r_state == IDLE);
   assign w_err    = req_error(req_size_i, req_addr_i[1:0],
                               {2'b00, req_addr_i[31:2]} >= c_num_words);
   assign w_index  = r_addr[AW+1:2];

   lsu_byte_lane u_lane (
      .size        (r_size),
      .addr_lo     (r_addr[1:0]),
      .is_unsigned (r_unsigned),
      .word        (mem_rdata_i),
      .wdata       (r_wdata),
      .load_data   (w_load_data),
      .merged      (w_merged)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next       = r_state;
      req_ready_o  = 1'b0;
      resp_valid_o = 1'b0;
      resp_err_o   = 1'b0;
      resp_rdata_o = '0;
      mem_re_o     = 1'b0;
      mem_raddr_o  = '0;
      mem_we_o     = 1'b0;
      mem_waddr_o  = '0;
      mem_wdata_o  = '0;
      case (r_state)
         IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               if (w_err)                  w_next = ERR;
               else if (!req_we_i)         w_next = LOAD;
               else if (req_size_i == SZ_W) w_next = ST_WORD;
               else                        w_next = RMW_RD;
            end
         end
         LOAD: begin
            mem_re_o    = 1'b1;
            mem_raddr_o = w_index;
            w_next      = RESP;
         end
         ST_WORD: begin
            mem_we_o    = 1'b1;
            mem_waddr_o = w_index;
            mem_wdata_o = r_wdata;
            w_next      = RESP;
         end
         RMW_RD: begin
            mem_re_o    = 1'b1;
            mem_raddr_o = w_index;
            w_next      = RMW_WR;
         end
         RMW_WR: begin
            mem_we_o    = 1'b1;
            mem_waddr_o = w_index;
            mem_wdata_o = r_merge;
            w_next      = RESP;
         end
         RESP: begin
            resp_valid_o = 1'b1;
            resp_rdata_o = r_rdata;
            w_next       = IDLE;
         end
         ERR: begin
            resp_valid_o = 1'b1;
            resp_err_o   = 1'b1;
            w_next       = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // r_rdata is cleared on accept so stores respond with zero data.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_we       <= 1'b0;
         r_size     <= 2'b00;
         r_unsigned <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rdata    <= '0;
         r_merge    <= '0;
      end else begin
         if (w_accept) begin
            r_we       <= req_we_i;
            r_size     <= req_size_i;
            r_unsigned <= req_unsigned_i;
            r_addr     <= req_addr_i[AW+1:0];
            r_wdata    <= req_wdata_i;
            r_rdata    <= '0;
         end
         if (r_state == LOAD)   r_rdata <= w_load_data;
         if (r_state == RMW_RD) r_merge <= w_merged;
      end
   end

   logic w_unused;
   assign w_unused = r_we;

endmodule
`default_nettype wire
